// File: rtl/repne_cmps_sequencer.sv
// REPNE CMPS sequencer: issues first/second uop pairs per iteration, counts ECX down,
// and terminates on ZF from writeback or on the count reaching zero.
module repne_cmps_sequencer #(
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned ZF_BIT = 6
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             req_v,
  input  logic [CNT_W-1:0] req_count,
  output logic             req_ready,
  output logic             uop_v,
  output logic             uop_first,
  output logic             uop_second,
  output logic [CNT_W-1:0] uop_iter,
  input  logic             uop_ready,
  input  logic             wb_v,
  input  logic [31:0]      wb_flags,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             zf_term,
  output logic             ecx_ld,
  output logic [CNT_W-1:0] ecx_out
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StIssue1 = 3'd1;
  localparam logic [2:0] StIssue2 = 3'd2;
  localparam logic [2:0] StWait   = 3'd3;
  localparam logic [2:0] StDone   = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             zf_term_q, zf_term_d;
  logic             ran_q, ran_d;
  logic [CNT_W-1:0] cnt_dec;
  logic             unused_flags;

  assign cnt_dec      = cnt_q - CNT_W'(1);
  assign unused_flags = ^wb_flags;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    zf_term_d = zf_term_q;
    ran_d     = ran_q;
    if (flush) begin
      state_d   = StIdle;
      cnt_d     = '0;
      zf_term_d = 1'b0;
      ran_d     = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_v) begin
            cnt_d     = req_count;
            zf_term_d = 1'b0;
            if (req_count == '0) begin
              ran_d   = 1'b0;
              state_d = StDone;
            end else begin
              ran_d   = 1'b1;
              state_d = StIssue1;
            end
          end
        end
        StIssue1: if (uop_ready) state_d = StIssue2;
        StIssue2: begin
          if (uop_ready) begin
            cnt_d   = cnt_dec;
            state_d = StWait;
          end
        end
        StWait: begin
          // cnt already holds the post-iteration value, so zero here means exhausted
          if (wb_v) begin
            if (wb_flags[ZF_BIT]) begin
              zf_term_d = 1'b1;
              state_d   = StDone;
            end else if (cnt_q == '0) begin
              zf_term_d = 1'b0;
              state_d   = StDone;
            end else begin
              state_d = StIssue1;
            end
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      zf_term_q <= 1'b0;
      ran_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      zf_term_q <= zf_term_d;
      ran_q     <= ran_d;
    end
  end

  always_comb begin
    req_ready  = (state_q == StIdle);
    busy       = (state_q != StIdle);
    uop_v      = 1'b0;
    uop_first  = 1'b0;
    uop_second = 1'b0;
    uop_iter   = '0;
    done       = 1'b0;
    zf_term    = 1'b0;
    ecx_ld     = 1'b0;
    ecx_out    = '0;
    case (state_q)
      StIssue1: begin
        uop_v     = 1'b1;
        uop_first = 1'b1;
      end
      StIssue2: begin
        uop_v      = 1'b1;
        uop_second = 1'b1;
        uop_iter   = cnt_dec;
      end
      StDone: begin
        // a flush landing on the completion cycle suppresses the completion
        done    = ~flush;
        zf_term = ~flush & zf_term_q;
        ecx_ld  = ~flush & ran_q;
        ecx_out = flush ? '0 : cnt_q;
      end
      default: ;
    endcase
  end

endmodule
